// File: rtl/mem_issue_ctrl.sv
// Issue sequencer between the memory-ordering unit and the data memory port.
// Accepts one ordered tag at a time, runs the memory access, broadcasts load results on the CDB.
module mem_issue_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          mem_tag,
  input  logic [5*ADDR_W-1:0] address_bus,
  input  logic [2*ADDR_W-1:0] store_data_bus,
  output logic                remove,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [ADDR_W-1:0]   dmem_wdata,
  input  logic                dmem_ack,
  input  logic [ADDR_W-1:0]   dmem_rdata,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [3:0]          cdb_tag,
  output logic [ADDR_W-1:0]   cdb_data,
  output logic [4:0]          rs_free,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, REQ, BCAST} state_t;

  state_t            state;
  logic [3:0]        tag_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_wdata;
  logic              sel_valid;
  logic              sel_store;

  // Release bit ordering: ld_1..ld_3 on bits 4..2, st_1/st_2 on bits 1..0.
  function automatic logic [4:0] free_mask(input logic [3:0] t);
    logic [4:0] m;
    m = 5'b00000;
    case (t)
      4'd6:    m = 5'b10000;
      4'd7:    m = 5'b01000;
      4'd8:    m = 5'b00100;
      4'd9:    m = 5'b00010;
      4'd10:   m = 5'b00001;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_valid = 1'b1;
    sel_store = 1'b0;
    case (mem_tag)
      4'd6: sel_addr = address_bus[2*ADDR_W +: ADDR_W];
      4'd7: sel_addr = address_bus[3*ADDR_W +: ADDR_W];
      4'd8: sel_addr = address_bus[4*ADDR_W +: ADDR_W];
      4'd9: begin
        sel_addr  = address_bus[0 +: ADDR_W];
        sel_wdata = store_data_bus[0 +: ADDR_W];
        sel_store = 1'b1;
      end
      4'd10: begin
        sel_addr  = address_bus[ADDR_W +: ADDR_W];
        sel_wdata = store_data_bus[ADDR_W +: ADDR_W];
        sel_store = 1'b1;
      end
      default: sel_valid = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tag_q      <= '0;
      remove     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      cdb_req    <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      rs_free    <= '0;
    end else begin
      remove  <= 1'b0;
      rs_free <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state      <= REQ;
            tag_q      <= mem_tag;
            remove     <= 1'b1;
            dmem_req   <= 1'b1;
            dmem_we    <= sel_store;
            dmem_addr  <= sel_addr;
            dmem_wdata <= sel_wdata;
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            if (dmem_we) begin
              state   <= IDLE;
              rs_free <= free_mask(tag_q);
            end else begin
              state    <= BCAST;
              cdb_req  <= 1'b1;
              cdb_tag  <= tag_q;
              cdb_data <= dmem_rdata;
            end
          end
        end
        BCAST: begin
          if (cdb_grant) begin
            state    <= IDLE;
            cdb_req  <= 1'b0;
            cdb_tag  <= '0;
            cdb_data <= '0;
            rs_free  <= free_mask(tag_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_issue_ctrl.sv
// Randomized self-checking bench for mem_issue_ctrl; expected cycle schedule is derived
// per transaction from the tag, the ack delay and the grant delay.
module tb_mem_issue_ctrl;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     mem_tag = '0;
  logic [5*W-1:0] address_bus = '0;
  logic [2*W-1:0] store_data_bus = '0;
  logic           remove, dmem_req, dmem_we, cdb_req, busy;
  logic [W-1:0]   dmem_addr, dmem_wdata, cdb_data;
  logic           dmem_ack = 1'b0;
  logic [W-1:0]   dmem_rdata = '0;
  logic           cdb_grant = 1'b0;
  logic [3:0]     cdb_tag;
  logic [4:0]     rs_free;

  int n_vec = 0;
  int n_err = 0;

  mem_issue_ctrl #(.ADDR_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .mem_tag(mem_tag), .address_bus(address_bus),
    .store_data_bus(store_data_bus), .remove(remove), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rs_free(rs_free), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic int slot(input logic [3:0] t);
    case (t)
      4'd9:    return 0;
      4'd10:   return 1;
      4'd6:    return 2;
      4'd7:    return 3;
      default: return 4;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_buses();
    for (int s = 0; s < 5; s++) address_bus[s*W +: W] = rnd64();
    store_data_bus = {rnd64(), rnd64()};
  endtask

  task automatic check_all_zero(input string ctx);
    chk({ctx, "_remove"}, remove, 0);
    chk({ctx, "_dmem_req"}, dmem_req, 0);
    chk({ctx, "_dmem_we"}, dmem_we, 0);
    chk({ctx, "_dmem_addr"}, dmem_addr, 0);
    chk({ctx, "_dmem_wdata"}, dmem_wdata, 0);
    chk({ctx, "_cdb_req"}, cdb_req, 0);
    chk({ctx, "_cdb_tag"}, cdb_tag, 0);
    chk({ctx, "_cdb_data"}, cdb_data, 0);
    chk({ctx, "_rs_free"}, rs_free, 0);
    chk({ctx, "_busy"}, busy, 0);
  endtask

  // Starts in an IDLE cycle, ends in the cycle carrying the rs_free pulse (also IDLE).
  task automatic run_txn(input logic [3:0] tag, input int ack_dly, input int grant_dly,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata);
    bit         is_ld, is_st;
    logic [4:0] exp_free;
    is_ld = (tag >= 4'd6) && (tag <= 4'd8);
    is_st = (tag == 4'd9) || (tag == 4'd10);
    scramble_buses();
    mem_tag   = tag;
    dmem_ack  = 1'($urandom_range(0, 1));
    cdb_grant = 1'($urandom_range(0, 1));
    if (!(is_ld || is_st)) begin
      step();
      chk("ign_busy", busy, 0);
      chk("ign_remove", remove, 0);
      chk("ign_dmem_req", dmem_req, 0);
      chk("ign_cdb_req", cdb_req, 0);
      mem_tag = '0;
      dmem_ack = 1'b0;
      cdb_grant = 1'b0;
      return;
    end
    address_bus[slot(tag)*W +: W] = addr;
    if (tag == 4'd9)  store_data_bus[0 +: W] = wdata;
    if (tag == 4'd10) store_data_bus[W +: W] = wdata;
    exp_free = 5'(1 << (10 - int'(tag)));
    step();
    for (int i = 0; i <= ack_dly; i++) begin
      chk("req_dmem_req", dmem_req, 1);
      chk("req_dmem_we", dmem_we, 64'(is_st));
      chk("req_dmem_addr", dmem_addr, addr);
      chk("req_dmem_wdata", dmem_wdata, is_st ? wdata : 64'd0);
      chk("req_remove", remove, 64'(i == 0));
      chk("req_busy", busy, 1);
      chk("req_cdb_req", cdb_req, 0);
      chk("req_rs_free", rs_free, 0);
      mem_tag = 4'($urandom_range(0, 15));
      scramble_buses();
      cdb_grant = 1'($urandom_range(0, 1));
      dmem_ack = (i == ack_dly);
      dmem_rdata = (i == ack_dly) ? rdata : rnd64();
      step();
    end
    dmem_ack = 1'b0;
    if (is_ld) begin
      for (int j = 0; j <= grant_dly; j++) begin
        chk("bc_cdb_req", cdb_req, 1);
        chk("bc_cdb_tag", cdb_tag, 64'(tag));
        chk("bc_cdb_data", cdb_data, rdata);
        chk("bc_dmem_req", dmem_req, 0);
        chk("bc_dmem_addr", dmem_addr, 0);
        chk("bc_remove", remove, 0);
        chk("bc_rs_free", rs_free, 0);
        chk("bc_busy", busy, 1);
        mem_tag = 4'($urandom_range(0, 15));
        dmem_ack = 1'($urandom_range(0, 1));
        dmem_rdata = rnd64();
        cdb_grant = (j == grant_dly);
        step();
      end
    end
    cdb_grant = 1'b0;
    dmem_ack = 1'b0;
    chk("done_rs_free", rs_free, 64'(exp_free));
    chk("done_busy", busy, 0);
    chk("done_dmem_req", dmem_req, 0);
    chk("done_dmem_we", dmem_we, 0);
    chk("done_cdb_req", cdb_req, 0);
    chk("done_cdb_tag", cdb_tag, 0);
    chk("done_cdb_data", cdb_data, 0);
    chk("done_remove", remove, 0);
    mem_tag = '0;
  endtask

  initial begin
    mem_tag = 4'd6;
    repeat (3) step();
    check_all_zero("rst");
    rst_n = 1'b1;
    run_txn(4'd6, 0, 0, rnd64(), 64'd0, rnd64());

    run_txn(4'd7, 0, 0, 64'h100, 64'd0, 64'hDEAD);
    run_txn(4'd10, 0, 0, 64'h40, 64'h55, 64'd0);
    run_txn(4'd8, 4, 3, rnd64(), 64'd0, rnd64());
    run_txn(4'd3, 0, 0, 64'd0, 64'd0, 64'd0);
    run_txn(4'd12, 0, 0, 64'd0, 64'd0, 64'd0);
    run_txn(4'd9, 2, 0, rnd64(), rnd64(), 64'd0);

    repeat (200) begin
      run_txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), rnd64(), rnd64(), rnd64());
    end

    // Reset while a load is in REQ: everything drops without completing.
    scramble_buses();
    mem_tag = 4'd7;
    step();
    chk("mid_dmem_req_before", dmem_req, 1);
    mem_tag = '0;
    dmem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    step();
    step();
    chk("mid_rs_free_held", rs_free, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);
    run_txn(4'd8, 1, 1, rnd64(), 64'd0, rnd64());
    run_txn(4'd9, 0, 0, rnd64(), rnd64(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
